data_memory_ctrl: RTL and testbench

Parametrised successor to the single-cycle data memory in the MIPS datapath. Accepts word, halfword and byte loads and stores through a valid/ready request port and returns one response per request after a configurable number of wait states. Loads are sign- or zero-extended. Misaligned, out-of-range and illegal-size accesses are reported as faults instead of silently corrupting memory. Sits between the MEM stage and the data RAM.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/data_memory_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller: access sizes,
// fault codes, FSM states and the latched request record.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISALIGN = 2'd1;
  localparam logic [1:0] FC_RANGE    = 2'd2;
  localparam logic [1:0] FC_SIZE     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    case (size)
      SZ_HALF: r = addr_lo[0];
      SZ_WORD: r = (addr_lo != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data for
// stores, lane extraction plus sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] write_data,
  input  logic [31:0] raw_word,
  input  logic        is_unsigned,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_en    = 4'b0000;
    store_data = 32'h0000_0000;
    load_data  = 32'h0000_0000;
    byte_s     = raw_word[{addr_lo, 3'b000} +: 8];
    half_s     = raw_word[{addr_lo[1], 4'b0000} +: 16];
    // Store data is replicated across lanes so the byte enables alone pick the target.
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        store_data = {4{write_data[7:0]}};
        if (is_unsigned) begin
          load_data = {24'h00_0000, byte_s};
        end else begin
          load_data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SZ_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data[15:0]}};
        if (is_unsigned) begin
          load_data = {16'h0000, half_s};
        end else begin
          load_data = {{16{half_s[15]}}, half_s};
        end
      end
      SZ_WORD: begin
        byte_en    = 4'b1111;
        store_data = write_data;
        load_data  = raw_word;
      end
      default: begin
        byte_en    = 4'b0000;
        store_data = 32'h0000_0000;
        load_data  = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready request port, configurable wait states,
// sub-word loads/stores with extension, and fault reporting instead of corruption.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_1000,
  parameter int unsigned DEPTH_WORDS = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              fault_q, fault_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  req_t              in_s, cur_s;
  logic              commit_s, in_range_s, mem_we_s;
  logic [1:0]        fc_s;
  logic [31:0]       off_s;
  logic [IDX_W-1:0]  idx_s;
  logic [3:0]        be_s;
  logic [31:0]       st_data_s, ld_data_s;

  // With no wait states the commit edge is the accept edge, so checks must see the live request.
  always_comb begin
    in_s.wr    = req_write;
    in_s.size  = req_size;
    in_s.uns   = req_unsigned;
    in_s.addr  = address;
    in_s.wdata = write_data;
    if (state_q == ST_IDLE) begin
      cur_s = in_s;
    end else begin
      cur_s = req_q;
    end
    commit_s   = ((state_q == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                 ((state_q == ST_BUSY) && (cnt_q == 4'd0));
    off_s      = cur_s.addr - BASE_ADDR;
    idx_s      = IDX_W'(off_s >> 2);
    in_range_s = (cur_s.addr >= BASE_ADDR) && ({1'b0, cur_s.addr} < LIMIT);
    if (cur_s.size == SZ_ILL) begin
      fc_s = FC_SIZE;
    end else if (!in_range_s) begin
      fc_s = FC_RANGE;
    end else if (is_misaligned(cur_s.size, cur_s.addr[1:0])) begin
      fc_s = FC_MISALIGN;
    end else begin
      fc_s = FC_NONE;
    end
    mem_we_s   = commit_s && cur_s.wr && (fc_s == FC_NONE);
  end

  dmem_lane_align u_align (
    .size        (cur_s.size),
    .addr_lo     (cur_s.addr[1:0]),
    .write_data  (cur_s.wdata),
    .raw_word    (mem_q[idx_s]),
    .is_unsigned (cur_s.uns),
    .byte_en     (be_s),
    .store_data  (st_data_s),
    .load_data   (ld_data_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    read_data_d  = read_data_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d = in_s;
          if (WAIT_STATES > 0) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Result registers only move on the commit edge and hold until the next one.
    if (commit_s) begin
      fault_d      = (fc_s != FC_NONE);
      fault_code_d = fc_s;
      if ((fc_s == FC_NONE) && !cur_s.wr) begin
        read_data_d = ld_data_s;
      end else begin
        read_data_d = 32'h0000_0000;
      end
    end else begin
      read_data_d  = read_data_q;
    end
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      req_q        <= '0;
      read_data_q  <= 32'h0000_0000;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      read_data_q  <= read_data_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Storage array is deliberately not reset so committed stores survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= st_data_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign read_data  = read_data_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: two controllers (0 and 3 wait states); stimulus pushes
// expected responses, a negedge monitor pops and compares them.
module tb_data_memory_ctrl;

  localparam int W0 = 0;
  localparam int W1 = 3;
  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, ILL = 2'd3;

  typedef struct {
    logic [31:0] data;
    logic        flt;
    logic [1:0]  code;
    int          acc;
    string       name;
  } exp_t;

  logic        clk;
  logic [1:0]  rst_n, req_valid, req_ready, req_write, req_unsigned, resp_valid, fault;
  logic [1:0]  req_size [2];
  logic [1:0]  fault_code [2];
  logic [31:0] address [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  data_memory_ctrl #(.BASE_ADDR(32'h1000_1000), .DEPTH_WORDS(16), .WAIT_STATES(W0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .address(address[0]), .write_data(write_data[0]), .resp_valid(resp_valid[0]),
    .read_data(read_data[0]), .fault(fault[0]), .fault_code(fault_code[0]));

  data_memory_ctrl #(.BASE_ADDR(32'h1000_1000), .DEPTH_WORDS(16), .WAIT_STATES(W1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .address(address[1]), .write_data(write_data[1]), .resp_valid(resp_valid[1]),
    .read_data(read_data[1]), .fault(fault[1]), .fault_code(fault_code[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic compare(input int d, input exp_t e);
    chk({e.name, "_data"}, read_data[d], e.data);
    chk({e.name, "_fault"}, 32'(fault[d]), 32'(e.flt));
    chk({e.name, "_code"}, 32'(fault_code[d]), 32'(e.code));
    // Response sits in the (WAIT_STATES+2)th cycle counting the accept cycle.
    chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'((d == 0) ? W0 : W1));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (resp_valid[d]) begin
        if (qsize(d) == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0", d);
        end else if (d == 0) begin
          compare(0, q0.pop_front());
        end else begin
          compare(1, q1.pop_front());
        end
      end
    end
  end

  task automatic drive(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    address[d]      = addr;
    write_data[d]   = wd;
  endtask

  task automatic push(input int d, input logic [31:0] ed, input logic [1:0] ec, input string nm);
    exp_t e;
    e.data = ed;
    e.flt  = (ec != 2'd0);
    e.code = ec;
    e.acc  = cyc + 1;
    e.name = nm;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_done(input int d, input string nm);
    int g = 0;
    while (qsize(d) != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no response expected one within 40 cycles", nm);
      if (d == 0) q0.delete();
      else q1.delete();
    end
  endtask

  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] ed, input logic [1:0] ec, input string nm);
    int g = 0;
    @(negedge clk);
    while (!req_ready[d] && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_ready: got req_ready=0 expected 1", nm);
    end
    drive(d, wr, sz, uns, addr, wd);
    push(d, ed, ec, nm);
    @(posedge clk);
    #1;
    // Inputs are scrambled after acceptance; the controller must use its latched copy.
    req_valid[d]  = 1'b0;
    address[d]    = 32'hFFFF_FFFF;
    write_data[d] = ~wd;
    req_size[d]   = 2'd3;
    wait_done(d, nm);
  endtask

  task automatic chk_reset_vals(input int d, input string nm);
    chk({nm, "_ready"}, 32'(req_ready[d]), 32'd1);
    chk({nm, "_resp"}, 32'(resp_valid[d]), 32'd0);
    chk({nm, "_rdata"}, read_data[d], 32'h0000_0000);
    chk({nm, "_fault"}, 32'(fault[d]), 32'd0);
    chk({nm, "_code"}, 32'(fault_code[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc;
    rst_n = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; address[d] = 32'h0; write_data[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    chk_reset_vals(0, "rst0");
    chk_reset_vals(1, "rst1");
    rst_n = 2'b11;

    // WAIT_STATES = 0 controller
    issue(0, 1'b1, W, 1'b0, 32'h1000_1000, 32'h1111_2222, 32'h0, 2'd0, "sw0");
    issue(0, 1'b0, W, 1'b0, 32'h1000_1000, 32'h0, 32'h1111_2222, 2'd0, "lw0");
    issue(0, 1'b1, W, 1'b0, 32'h1000_1004, 32'h80FF_7F01, 32'h0, 2'd0, "sw4");
    issue(0, 1'b0, B, 1'b0, 32'h1000_1007, 32'h0, 32'hFFFF_FF80, 2'd0, "lb7");
    issue(0, 1'b0, B, 1'b1, 32'h1000_1007, 32'h0, 32'h0000_0080, 2'd0, "lbu7");
    issue(0, 1'b0, H, 1'b0, 32'h1000_1004, 32'h0, 32'h0000_7F01, 2'd0, "lh4");
    issue(0, 1'b1, B, 1'b0, 32'h1000_1005, 32'h1234_56AA, 32'h0, 2'd0, "sb5");
    issue(0, 1'b0, W, 1'b0, 32'h1000_1004, 32'h0, 32'h80FF_AA01, 2'd0, "lw4");
    repeat (2) @(negedge clk);
    chk("rdata_hold", read_data[0], 32'h80FF_AA01);
    issue(0, 1'b0, H, 1'b0, 32'h1000_1006, 32'h0, 32'hFFFF_80FF, 2'd0, "lh6");
    issue(0, 1'b0, H, 1'b1, 32'h1000_1006, 32'h0, 32'h0000_80FF, 2'd0, "lhu6");
    issue(0, 1'b0, W, 1'b0, 32'h1000_1002, 32'h0, 32'h0, 2'd1, "lw_misal");
    issue(0, 1'b0, H, 1'b1, 32'h1000_1005, 32'h0, 32'h0, 2'd1, "lh_misal");
    issue(0, 1'b1, W, 1'b0, 32'h1000_1040, 32'h5555_5555, 32'h0, 2'd2, "sw_oor");
    issue(0, 1'b0, W, 1'b0, 32'h1000_1000, 32'h0, 32'h1111_2222, 2'd0, "lw0_after_oor");
    issue(0, 1'b1, ILL, 1'b0, 32'h1000_0FFF, 32'h7777_7777, 32'h0, 2'd3, "ill_size");
    issue(0, 1'b1, W, 1'b0, 32'h1000_103C, 32'hCAFE_F00D, 32'h0, 2'd0, "sw_last");
    issue(0, 1'b0, W, 1'b0, 32'h1000_103C, 32'h0, 32'hCAFE_F00D, 2'd0, "lw_last");
    issue(0, 1'b1, B, 1'b0, 32'h1000_0FFF, 32'h0000_00EE, 32'h0, 2'd2, "sb_below");
    issue(0, 1'b0, W, 1'b0, 32'h1000_103C, 32'h0, 32'hCAFE_F00D, 2'd0, "lw_last_again");

    // WAIT_STATES = 3 controller
    issue(1, 1'b1, W, 1'b0, 32'h1000_1008, 32'h1234_5678, 32'h0, 2'd0, "sw_ws3");
    @(negedge clk);
    drive(1, 1'b0, W, 1'b0, 32'h1000_1008, 32'h0);
    push(1, 32'h1234_5678, 2'd0, "lw_ws3");
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    lowc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) drive(1, 1'b1, W, 1'b0, 32'h1000_1008, 32'hFFFF_FFFF);
      else req_valid[1] = 1'b0;
      if (req_ready[1]) break;
      lowc++;
    end
    chk("ready_low_cycles", 32'(lowc), 32'd4);
    wait_done(1, "lw_ws3");
    issue(1, 1'b0, W, 1'b0, 32'h1000_1008, 32'h0, 32'h1234_5678, 2'd0, "lw_after_drop");

    // Reset during BUSY of a store abandons it
    @(negedge clk);
    drive(1, 1'b1, W, 1'b0, 32'h1000_1008, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("busy_ready", 32'(req_ready[1]), 32'd0);
    rst_n[1] = 1'b0;
    #1;
    chk_reset_vals(1, "midrst");
    repeat (4) @(negedge clk);
    rst_n[1] = 1'b1;
    issue(1, 1'b0, W, 1'b0, 32'h1000_1008, 32'h0, 32'h1234_5678, 2'd0, "lw_after_rst");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
